// File: rtl/sid_bass_sequencer.sv
// Programmable step sequencer for the bass voice: plays a STEPS-slot pattern,
// stepping on prescaler ticks and driving the voice frequency and gate.
module sid_bass_sequencer #(
   parameter int STEPS     = 8,
   parameter int TICK_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [15:0]              prescaler,
   input  logic                     run,
   input  logic [$clog2(STEPS)-1:0] len_m1,
   input  logic [7:0]               step_len,
   input  logic [7:0]               gate_len,
   input  logic                     cfg_we,
   input  logic [$clog2(STEPS)-1:0] cfg_addr,
   input  logic [7:0]               cfg_data,
   output logic [6:0]               frequency,
   output logic                     gate,
   output logic [$clog2(STEPS)-1:0] step_idx,
   output logic                     step_strobe
);

   localparam int IDX_W = $clog2(STEPS);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PLAY = 1'b1
   } state_t;

   state_t           state_r;
   logic [7:0]       slot_r [STEPS];
   logic [8:0]       tick_cnt_r;
   logic [6:0]       frequency_r;
   logic             gate_r;
   logic [IDX_W-1:0] step_idx_r;
   logic             step_strobe_r;

   logic             tick_s;
   logic [8:0]       eff_len_s;
   logic [8:0]       cnt_inc_s;
   logic [8:0]       gate_len_s;
   logic [IDX_W-1:0] next_idx_s;
   logic [IDX_W-1:0] load_idx_s;
   logic [7:0]       load_slot_s;
   logic             gate_load_s;
   logic             unused_prescaler_s;

   assign unused_prescaler_s = &{1'b0, prescaler};

   // Tick detect, step length decode and next-slot selection for a LOAD
   always_comb begin
      tick_s     = &prescaler[TICK_BITS-1:0];
      eff_len_s  = (step_len == 8'd0) ? 9'd256 : {1'b0, step_len};
      gate_len_s = {1'b0, gate_len};
      cnt_inc_s  = tick_cnt_r + 9'd1;
      if (step_idx_r >= len_m1) begin
         next_idx_s = {IDX_W{1'b0}};
      end else begin
         next_idx_s = step_idx_r + IDX_W'(1);
      end
      if (state_r == IDLE) begin
         load_idx_s = {IDX_W{1'b0}};
      end else begin
         load_idx_s = next_idx_s;
      end
      load_slot_s = slot_r[load_idx_s];
      gate_load_s = load_slot_s[7] & (gate_len != 8'd0);
   end

   // Pattern memory; a same-cycle LOAD sees the pre-write contents
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STEPS; i++) begin
            slot_r[i] <= 8'h00;
         end
      end else if (cfg_we) begin
         slot_r[cfg_addr] <= cfg_data;
      end
   end

   // Playback FSM; stop has priority over any tick or step boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         tick_cnt_r    <= 9'd0;
         frequency_r   <= 7'd0;
         gate_r        <= 1'b0;
         step_idx_r    <= {IDX_W{1'b0}};
         step_strobe_r <= 1'b0;
      end else begin
         step_strobe_r <= 1'b0;
         case (state_r)
            IDLE: begin
               gate_r     <= 1'b0;
               step_idx_r <= {IDX_W{1'b0}};
               tick_cnt_r <= 9'd0;
               if (run) begin
                  state_r       <= PLAY;
                  step_idx_r    <= load_idx_s;
                  frequency_r   <= load_slot_s[6:0];
                  gate_r        <= gate_load_s;
                  step_strobe_r <= 1'b1;
               end
            end
            PLAY: begin
               if (!run) begin
                  state_r    <= IDLE;
                  gate_r     <= 1'b0;
                  step_idx_r <= {IDX_W{1'b0}};
                  tick_cnt_r <= 9'd0;
               end else if (tick_s) begin
                  if (cnt_inc_s == eff_len_s) begin
                     step_idx_r    <= load_idx_s;
                     frequency_r   <= load_slot_s[6:0];
                     gate_r        <= gate_load_s;
                     tick_cnt_r    <= 9'd0;
                     step_strobe_r <= 1'b1;
                  end else begin
                     tick_cnt_r <= cnt_inc_s;
                     // gate_len >= eff_len is a tie: gate carries into the next step
                     if ((cnt_inc_s == gate_len_s) && (gate_len_s < eff_len_s)) begin
                        gate_r <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign frequency   = frequency_r;
   assign gate        = gate_r;
   assign step_idx    = step_idx_r;
   assign step_strobe = step_strobe_r;

endmodule

// File: tb/tb_sid_bass_sequencer.sv
// Randomized and directed bench for sid_bass_sequencer; a behavioural model
// queues per-cycle expectations that an independent monitor compares.
module tb_sid_bass_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] prescaler;
   logic        run;
   logic [2:0]  len_m1;
   logic [7:0]  step_len;
   logic [7:0]  gate_len;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic [6:0]  frequency;
   logic        gate;
   logic [2:0]  step_idx;
   logic        step_strobe;

   always #5 clk = ~clk;

   sid_bass_sequencer #(.STEPS(8), .TICK_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .prescaler(prescaler), .run(run),
      .len_m1(len_m1), .step_len(step_len), .gate_len(gate_len),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .frequency(frequency), .gate(gate), .step_idx(step_idx),
      .step_strobe(step_strobe)
   );

   typedef struct packed {
      logic [6:0] f;
      logic       g;
      logic [2:0] idx;
      logic       s;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_on = 1'b0;

   // Reference model: playing flag, current step, ticks elapsed in the step
   bit         m_play;
   int         m_step;
   int         m_ticks;
   logic [6:0] m_freq;
   bit         m_gate;
   bit         m_strobe;
   logic [7:0] m_slot [8];

   function automatic void model_reset();
      m_play = 0; m_step = 0; m_ticks = 0; m_freq = 7'd0; m_gate = 0; m_strobe = 0;
      for (int i = 0; i < 8; i++) m_slot[i] = 8'h00;
   endfunction

   function automatic void model_load(int i);
      m_step   = i;
      m_freq   = m_slot[i][6:0];
      m_gate   = m_slot[i][7] && (gate_len != 8'd0);
      m_ticks  = 0;
      m_strobe = 1;
   endfunction

   // Predict the outputs after the coming clock edge from the current inputs
   function automatic void model_step();
      bit tick;
      int eff;
      tick = (prescaler[7:0] == 8'hFF);
      eff  = (step_len == 8'd0) ? 256 : int'(step_len);
      m_strobe = 0;
      if (!rst_n) begin
         model_reset();
      end else begin
         if (!m_play) begin
            m_gate = 0; m_step = 0; m_ticks = 0;
            if (run) begin
               model_load(0);
               m_play = 1;
            end
         end else if (!run) begin
            m_play = 0; m_gate = 0; m_step = 0; m_ticks = 0;
         end else if (tick) begin
            m_ticks++;
            if (m_ticks == eff) begin
               model_load((m_step >= int'(len_m1)) ? 0 : m_step + 1);
            end else if (m_ticks == int'(gate_len) && int'(gate_len) < eff) begin
               m_gate = 0;
            end
         end
         if (cfg_we) m_slot[cfg_addr] = cfg_data;
      end
      exp_q.push_back({m_freq, m_gate, 3'(m_step), m_strobe});
   endfunction

   function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
      end
   endfunction

   // Monitor: compares every post-edge output against the queued expectation
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mon_on) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL underflow t=%0t no expectation queued", $time);
            end else begin
               mon_e = exp_q.pop_front();
               if ({frequency, gate, step_idx, step_strobe} !== mon_e) begin
                  miscompares++;
                  $display("FAIL cycle t=%0t got f=%0d g=%0b idx=%0d s=%0b want f=%0d g=%0b idx=%0d s=%0b",
                           $time, frequency, gate, step_idx, step_strobe,
                           mon_e.f, mon_e.g, mon_e.idx, mon_e.s);
               end
            end
         end
      end
   end

   // One clock: drive prescaler (tick or not), predict, advance to edge+2
   task automatic cyc(input bit t);
      logic [15:0] p;
      p = 16'($urandom);
      if (t) p[7:0] = 8'hFF;
      else if (p[7:0] == 8'hFF) p[7:0] = 8'hFE;
      prescaler = p;
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      cyc(1'b0);
      cfg_we = 1'b0;
   endtask

   task automatic stop();
      run = 1'b0;
      cyc(1'b0);
      cyc(1'b0);
   endtask

   initial begin
      rst_n = 1'b0; run = 1'b0; prescaler = 16'h0000; len_m1 = 3'd0;
      step_len = 8'd4; gate_len = 8'd2; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'h00;
      @(posedge clk);
      #2;
      chk("reset_state", {frequency, gate, step_idx, step_strobe}, 32'd0);
      model_reset();
      mon_on = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      rst_n = 1'b1;
      cyc(1'b0);

      // Basic pattern
      wr(3'd0, 8'h96); wr(3'd1, 8'h11);
      len_m1 = 3'd1; step_len = 8'd4; gate_len = 8'd2; run = 1'b1;
      cyc(1'b0);
      chk("basic_load", {frequency, gate, step_strobe}, {7'd22, 1'b1, 1'b1});
      ticks(2);
      chk("basic_gate_fall", gate, 32'd0);
      ticks(2);
      chk("basic_step1", {frequency, gate, step_idx, step_strobe}, {7'd17, 1'b0, 3'd1, 1'b1});
      ticks(4);
      chk("basic_wrap", {frequency, gate, step_idx}, {7'd22, 1'b1, 3'd0});
      for (int i = 0; i < 30; i++) cyc(1'($urandom));
      stop();

      // Tie across the boundary
      wr(3'd1, 8'h94); gate_len = 8'd10; run = 1'b1;
      cyc(1'b0);
      ticks(3);
      chk("tie_hold", {frequency, gate}, {7'd22, 1'b1});
      ticks(1);
      chk("tie_next", {frequency, gate, step_idx}, {7'd20, 1'b1, 3'd1});
      for (int i = 0; i < 20; i++) cyc(1'($urandom));
      stop();

      // Stop on the same clock as a boundary tick
      run = 1'b1;
      cyc(1'b0);
      ticks(3);
      run = 1'b0;
      cyc(1'b1);
      chk("stop_priority", {frequency, gate, step_idx, step_strobe}, {7'd22, 1'b0, 3'd0, 1'b0});
      cyc(1'b0);

      // Write colliding with LOAD(1)
      wr(3'd1, 8'h91); gate_len = 8'd2; run = 1'b1;
      cyc(1'b0);
      ticks(3);
      cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'hA2;
      cyc(1'b1);
      cfg_we = 1'b0;
      chk("collide_old", {frequency, gate, step_idx}, {7'd17, 1'b1, 3'd1});
      ticks(8);
      chk("collide_new", {frequency, gate, step_idx}, {7'd34, 1'b1, 3'd1});
      stop();

      // Edge values: 256-tick steps, gate never rises, 8-step pattern
      step_len = 8'd0; gate_len = 8'd0; len_m1 = 3'd7;
      for (int i = 0; i < 8; i++) wr(3'(i), 8'h80 | 8'($urandom_range(0, 127)));
      run = 1'b1;
      cyc(1'b0);
      ticks(255);
      chk("len256_hold", step_idx, 32'd0);
      ticks(1);
      chk("len256_step", {gate, step_idx, step_strobe}, {1'b0, 3'd1, 1'b1});
      ticks(256 * 7 + 3);
      chk("len8_wrap", step_idx, 32'd0);
      stop();

      // Async reset mid-play with gate high
      wr(3'd0, 8'hC5); step_len = 8'd5; gate_len = 8'd3; len_m1 = 3'd1; run = 1'b1;
      cyc(1'b0);
      cyc(1'b1);
      rst_n = 1'b0;
      #1;
      chk("reset_async", {frequency, gate, step_idx, step_strobe}, 32'd0);
      cyc(1'b0);
      cyc(1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) cyc(1'b1);
      stop();

      // Randomized playback
      for (int i = 0; i < 2500; i++) begin
         cfg_we = ($urandom_range(0, 7) == 0);
         cfg_addr = 3'($urandom);
         cfg_data = 8'($urandom);
         if ($urandom_range(0, 15) == 0) len_m1 = 3'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            run = ~run;
            if (!run) begin
               step_len = 8'($urandom_range(0, 6));
               gate_len = 8'($urandom_range(0, 8));
            end
         end
         cyc(1'($urandom));
      end
      cfg_we = 1'b0;
      stop();

      mon_on = 1'b0;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
